bk_ay_psg_regif: RTL and testbench
==================================

# bk_ay_psg_regif

Responder end of the BK0010/0011 to AY-3-8910 bus: the PSG-side register interface that accepts BDIR/BC1/BC2 and the 8-bit data/address bus, decodes the four PSG bus commands, and implements the 16-entry PSG register file. It sits in front of the tone, noise and envelope generators, supplying their register contents, a per-write strobe and the envelope-restart pulse. All bus inputs are asynchronous to `clk` and are synchronized and glitch-filtered here.

## Interface
- `CHIP_ADDR`, 4'h0, value `da_in[7:4]` must carry during address latch for the chip to be selected
- `FILT_LEN`, 2, consecutive identical synchronized command samples required before a command is accepted (range 1..7)
- `clk`  input  1  system clock; one clock domain
- `rst_n`  input  1  asynchronous, active-low reset
- `bdir`  input  1  bus direction line (async)
- `bc1`  input  1  bus control 1 (async)
- `bc2`  input  1  bus control 2 (async)
- `da_in`  input  8  data/address bus in (async)
- `da_out`  output  8  read data
- `da_oe`  output  1  read drive enable
- `reg_addr`  output  4  latched register address
- `reg_wr`  output  1  one-cycle pulse when a register is written
- `reg_wdata`  output  8  value written, valid with `reg_wr`
- `env_restart`  output  1  one-cycle pulse on any write to R13
- `regs`  output  128  register file, R0 in bits [7:0] … R15 in [127:120]

## Operation
- Two-flop synchronizer on `bdir`, `bc1`, `bc2` and all `da_in` bits.
- Raw command decode from synchronized {bdir,bc2,bc1}: 000,010,101 INACT; 001,100,111 LADDR; 110 WRPSG; 011 RDPSG.
- Filter: counter tracks the raw code; accepted command updates only after `FILT_LEN` consecutive equal samples; any change restarts the count. Transitional codes shorter than `FILT_LEN` never take effect.
- FSM on accepted command: IDLE, LATCH, WRITE, READ; each state entered directly from any other on the matching accepted command (INACT -> IDLE).
- LATCH: every cycle, `reg_addr` <= `da_in[3:0]`, `selected` <= (`da_in[7:4]` == `CHIP_ADDR`). Last sample before leaving LATCH wins.
- WRITE: every cycle, write holding register <= synchronized `da_in`. On the cycle the FSM leaves WRITE (any target state), if `selected`: `regs[reg_addr]` <= holding value (masked, see Configuration), `reg_wr`=1, `reg_wdata`=stored value, `env_restart`=1 when `reg_addr`==13. Not selected: no write, no pulses.
- READ: `da_oe`=`selected`; `da_out`=`regs[reg_addr]` (registered, updated every cycle in READ). Outside READ `da_oe`=0, `da_out`=0.
- Address persists across any number of writes/reads until the next LATCH.
- Write then immediate read of the same register returns the new value (register updated before READ output register samples).

## Timing
- Reset values: all `regs`=0, `reg_addr`=0, `selected`=0, FSM IDLE, filter accepted command INACT, `da_out`=0, `da_oe`=0, `reg_wr`=0, `reg_wdata`=0, `env_restart`=0.
- Command latency: raw bus change to FSM state change = 2 (sync) + `FILT_LEN` cycles.
- Write commit: exit of WRITE; `regs` shows new value the following cycle; `reg_wr`/`env_restart` exactly one cycle wide.
- Read: `da_oe`/`da_out` valid one cycle after entering READ; drop one cycle after leaving.
- Reset asserted mid-WRITE: write abandoned, no pulse; mid-READ: `da_oe` drops immediately (asynchronous).
- Bus commands require the bus master to hold each code at least 2+`FILT_LEN`+1 clocks.

## Configuration
- `AY_REGMASK_EN` defined: writes store data ANDed with AY bit masks — R1,R3,R5,R13: 0x0F; R6,R8,R9,R10: 0x1F; others 0xFF; `reg_wdata` and reads show masked value (AY-3-8910 behaviour).
- Not defined: all 8 bits stored and read back for every register (YM2149 behaviour).

## Test plan
- Reset: assert `rst_n`=0 mid-activity -> all outputs 0, `regs`=0, `da_oe`=0.
- LADDR 0x07, WRPSG 0x38, INACT -> one `reg_wr` pulse, `reg_wdata`=0x38, `regs[63:56]`=0x38, `env_restart`=0.
- LADDR 0x0D, WRPSG 0xFE, INACT -> R13 = 0x0E with `AY_REGMASK_EN`, 0xFE without; `env_restart` one-cycle pulse.
- LADDR 0x05 then RDPSG after R5 write of 0x0A -> `da_oe`=1, `da_out`=0x0A; INACT -> `da_oe`=0 one cycle later.
- LADDR 0x12 (wrong chip), WRPSG 0x55, RDPSG -> no `reg_wr`, `da_oe` stays 0, `regs` unchanged.
- Inject 1-cycle transitional code 010 and 111 between WRPSG and INACT -> no spurious LATCH, address unchanged, exactly one write.

Source files
------------

// File: rtl/bk_ay_psg_regif.sv
// AY-3-8910 style PSG bus responder: synchronizes and filters BDIR/BC1/BC2 commands and holds the 16 x 8 register file.
// Optional build macro AY_REGMASK_EN applies the AY-3-8910 per-register bit masks to stored data.
module bk_ay_psg_regif #(
    parameter logic [3:0] CHIP_ADDR = 4'h0,
    parameter int         FILT_LEN  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bdir,
    input  logic         bc1,
    input  logic         bc2,
    input  logic [7:0]   da_in,
    output logic [7:0]   da_out,
    output logic         da_oe,
    output logic [3:0]   reg_addr,
    output logic         reg_wr,
    output logic [7:0]   reg_wdata,
    output logic         env_restart,
    output logic [127:0] regs
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;
    localparam logic [2:0] FILT_THR = 3'(FILT_LEN);

    logic [10:0] r_sync1;
    logic [10:0] r_sync2;
    logic [2:0]  r_last_code;
    logic [2:0]  r_cnt;
    logic [1:0]  r_state;
    logic [3:0]  r_addr;
    logic        r_selected;
    logic [7:0]  r_hold;
    logic [7:0]  r_regs [16];
    logic [7:0]  r_dout;
    logic        r_oe;
    logic        r_wr;
    logic [7:0]  r_wdata;
    logic        r_env;

    logic [2:0]  w_code;
    logic [7:0]  w_da;
    logic [1:0]  w_cmd;
    logic [2:0]  w_cnt_next;
    logic [1:0]  w_state_next;
    logic        w_commit;
    logic [7:0]  w_wdata;

    function automatic logic [7:0] f_mask(input logic [3:0] a);
`ifdef AY_REGMASK_EN
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13:  f_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10:  f_mask = 8'h1F;
            default:                  f_mask = 8'hFF;
        endcase
`else
        f_mask = (a == a) ? 8'hFF : 8'hFF;
`endif
    endfunction

    assign w_code = r_sync2[10:8];
    assign w_da   = r_sync2[7:0];

    always_comb begin
        w_cmd = ST_IDLE;
        case (w_code)
            3'b001, 3'b100, 3'b111: w_cmd = ST_LATCH;
            3'b110:                 w_cmd = ST_WRITE;
            3'b011:                 w_cmd = ST_READ;
            default:                w_cmd = ST_IDLE;
        endcase
    end

    // The run length counts raw codes, so e.g. 001 -> 111 restarts it even though both mean LADDR.
    assign w_cnt_next   = (w_code != r_last_code) ? 3'd1 :
                          (r_cnt == 3'd7)         ? 3'd7 : r_cnt + 3'd1;
    assign w_state_next = (w_cnt_next >= FILT_THR) ? w_cmd : r_state;
    assign w_commit     = (r_state == ST_WRITE) && (w_state_next != ST_WRITE) && r_selected;
    assign w_wdata      = r_hold & f_mask(r_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_last_code <= 3'b000;
            r_cnt       <= 3'd0;
            r_state     <= ST_IDLE;
        end else begin
            r_sync1     <= {bdir, bc2, bc1, da_in};
            r_sync2     <= r_sync1;
            r_last_code <= w_code;
            r_cnt       <= w_cnt_next;
            r_state     <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= 4'd0;
            r_selected <= 1'b0;
            r_hold     <= 8'd0;
            r_wr       <= 1'b0;
            r_wdata    <= 8'd0;
            r_env      <= 1'b0;
            r_dout     <= 8'd0;
            r_oe       <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 8'd0;
            end
        end else begin
            if (r_state == ST_LATCH) begin
                r_addr     <= w_da[3:0];
                r_selected <= (w_da[7:4] == CHIP_ADDR);
            end
            if (r_state == ST_WRITE) begin
                r_hold <= w_da;
            end
            r_wr  <= w_commit;
            r_env <= w_commit && (r_addr == 4'd13);
            if (w_commit) begin
                r_regs[r_addr] <= w_wdata;
                r_wdata        <= w_wdata;
            end
            // Commit happens on the WRITE exit edge, so a direct WRITE->READ reads back the new value.
            r_dout <= (r_state == ST_READ) ? r_regs[r_addr] : 8'd0;
            r_oe   <= (r_state == ST_READ) && r_selected;
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_regs_out
            assign regs[gi*8 +: 8] = r_regs[gi];
        end
    endgenerate

    assign da_out      = r_dout;
    assign da_oe       = r_oe;
    assign reg_addr    = r_addr;
    assign reg_wr      = r_wr;
    assign reg_wdata   = r_wdata;
    assign env_restart = r_env;

endmodule

// File: tb/tb_bk_ay_psg_regif.sv
// Scoreboard bench for bk_ay_psg_regif: expected writes/reads are queued at stimulus time and
// popped by a monitor on each reg_wr pulse or da_oe rising edge.
module tb_bk_ay_psg_regif;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bdir = 1'b0;
    logic         bc1 = 1'b0;
    logic         bc2 = 1'b0;
    logic [7:0]   da_in = 8'd0;
    logic [7:0]   da_out;
    logic         da_oe;
    logic [3:0]   reg_addr;
    logic         reg_wr;
    logic [7:0]   reg_wdata;
    logic         env_restart;
    logic [127:0] regs;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
        logic       e;
    } wexp_t;

    wexp_t      wq[$];
    logic [7:0] rq[$];
    logic [7:0] m_regs [16];
    int         total = 0;
    int         bad = 0;
    logic       prev_oe = 1'b0;

    localparam logic [2:0] C_INACT = 3'b000;
    localparam logic [2:0] C_LADDR = 3'b111;
    localparam logic [2:0] C_WRPSG = 3'b110;
    localparam logic [2:0] C_RDPSG = 3'b011;

    bk_ay_psg_regif #(.CHIP_ADDR(4'h0), .FILT_LEN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bdir        (bdir),
        .bc1         (bc1),
        .bc2         (bc2),
        .da_in       (da_in),
        .da_out      (da_out),
        .da_oe       (da_oe),
        .reg_addr    (reg_addr),
        .reg_wr      (reg_wr),
        .reg_wdata   (reg_wdata),
        .env_restart (env_restart),
        .regs        (regs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    function automatic logic [7:0] tb_mask(input logic [3:0] a);
`ifdef AY_REGMASK_EN
        if (a == 4'd1 || a == 4'd3 || a == 4'd5 || a == 4'd13) return 8'h0F;
        if (a == 4'd6 || a == 4'd8 || a == 4'd9 || a == 4'd10) return 8'h1F;
        return 8'hFF;
`else
        return (a == 4'd15) ? 8'hFF : 8'hFF;
`endif
    endfunction

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    task automatic bus(input logic [2:0] c, input logic [7:0] d, input int n);
        @(negedge clk);
        {bdir, bc2, bc1} = c;
        da_in = d;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic latch_addr(input logic [7:0] a);
        bus(C_LADDR, a, 6);
        bus(C_INACT, a, 6);
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] m;
        m = d & tb_mask(a);
        wq.push_back('{a: a, d: m, e: (a == 4'd13)});
        m_regs[a] = m;
    endtask

    // Monitor: every reg_wr pulse and every da_oe rise must match the head of its queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_oe <= 1'b0;
        end else begin
            if (reg_wr) begin
                if (wq.size() == 0) begin
                    chk("unexpected_reg_wr", {reg_addr, reg_wdata}, 0);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    chk("wr_addr", reg_addr, w.a);
                    chk("wr_data", reg_wdata, w.d);
                    chk("wr_env", env_restart, w.e);
                end
            end else if (env_restart) begin
                chk("env_without_wr", env_restart, 0);
            end
            if (da_oe && !prev_oe) begin
                if (rq.size() == 0) begin
                    chk("unexpected_da_oe", da_oe, 0);
                end else begin
                    logic [7:0] r;
                    r = rq.pop_front();
                    chk("rd_data", da_out, r);
                end
            end
            prev_oe <= da_oe;
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;

        // Reset with bus activity present
        repeat (2) @(negedge clk);
        {bdir, bc2, bc1} = C_WRPSG;
        da_in = 8'hA5;
        repeat (4) @(negedge clk);
        chk("rst_regs", regs, 128'd0);
        chk("rst_outs", {da_out, da_oe, reg_addr, reg_wr, reg_wdata, env_restart}, 0);
        {bdir, bc2, bc1} = C_INACT;
        da_in = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // R7 <- 0x38
        latch_addr(8'h07);
        chk("laddr_07", reg_addr, 4'd7);
        expect_write(4'd7, 8'h38);
        bus(C_WRPSG, 8'h38, 6);
        bus(C_INACT, 8'h38, 6);
        chk("r7_slice", regs[63:56], 8'h38);

        // R13 <- 0xFE with envelope restart
        latch_addr(8'h0D);
        expect_write(4'd13, 8'hFE);
        bus(C_WRPSG, 8'hFE, 6);
        bus(C_INACT, 8'hFE, 6);
`ifdef AY_REGMASK_EN
        chk("r13_slice", regs[111:104], 8'h0E);
`else
        chk("r13_slice", regs[111:104], 8'hFE);
`endif

        // R5 <- 0x0A, then read back
        latch_addr(8'h05);
        expect_write(4'd5, 8'h0A);
        bus(C_WRPSG, 8'h0A, 6);
        bus(C_INACT, 8'h0A, 6);
        latch_addr(8'h05);
        rq.push_back(8'h0A);
        bus(C_RDPSG, 8'h0A, 6);
        chk("rd_oe_on", da_oe, 1'b1);
        @(negedge clk);
        {bdir, bc2, bc1} = C_INACT;
        repeat (4) @(posedge clk);
        #1 chk("oe_still_on", da_oe, 1'b1);
        @(posedge clk);
        #1 chk("oe_dropped", {da_oe, da_out}, 9'd0);
        repeat (4) @(negedge clk);

        // Direct WRITE -> READ returns the freshly written value
        expect_write(4'd5, 8'h03);
        rq.push_back(8'h03);
        bus(C_WRPSG, 8'h03, 6);
        bus(C_RDPSG, 8'h03, 6);
        bus(C_INACT, 8'h03, 6);

        // Wrong chip: no write, no drive
        latch_addr(8'h12);
        chk("laddr_12_addr", reg_addr, 4'd2);
        bus(C_WRPSG, 8'h55, 6);
        bus(C_RDPSG, 8'h55, 6);
        chk("wrong_chip_oe", da_oe, 1'b0);
        bus(C_INACT, 8'h55, 8);
        chk("wrong_chip_regs", regs, model_flat());

        // One-cycle transitional codes 010 and 111 between WRPSG and INACT
        latch_addr(8'h03);
        expect_write(4'd3, 8'h77);
        bus(C_WRPSG, 8'h77, 6);
        bus(3'b010, 8'h77, 1);
        bus(3'b111, 8'h77, 1);
        bus(C_INACT, 8'h77, 8);
        chk("glitch_addr", reg_addr, 4'd3);
        chk("glitch_regs", regs, model_flat());

        // Reset in the middle of a READ drops da_oe immediately
        latch_addr(8'h07);
        rq.push_back(8'h38);
        bus(C_RDPSG, 8'h38, 6);
        chk("pre_rst_oe", da_oe, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        {bdir, bc2, bc1} = C_INACT;
        #1 chk("rst_read_oe", {da_oe, da_out}, 9'd0);
        for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
        chk("rst_read_regs", regs, model_flat());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset in the middle of a WRITE abandons it
        latch_addr(8'h01);
        bus(C_WRPSG, 8'h99, 6);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        {bdir, bc2, bc1} = C_INACT;
        #1 chk("rst_write_outs", {reg_wr, env_restart, reg_wdata, reg_addr}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_write_regs", regs, model_flat());

        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
